// File: rtl/servo_pkg.sv
// Shared servo types and default timing constants (50 MHz clock, 20 ms frame).
package servo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH        = 32;
  localparam int unsigned DEF_FRAME_CYCLES = 1000000;
  localparam int unsigned DEF_MIN_PW       = 50000;
  localparam int unsigned DEF_MAX_PW       = 100000;
  localparam int unsigned DEF_INIT_PW      = 75000;
  localparam int unsigned DEF_STEP         = 500;
  localparam int unsigned DEF_HOLD_FRAMES  = 50;

endpackage

// File: rtl/servo_pwm_frame.sv
// Free-running PWM frame counter with end-of-frame tick and registered compare output.
module servo_pwm_frame
  import servo_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic [WIDTH-1:0] cur_pw,
  output logic             pwm_out,
  output logic             frame_tick
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(FRAME_CYCLES - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    frame_tick = (cnt_q == LAST_CNT);
    cnt_d      = frame_tick ? '0 : cnt_q + WIDTH'(1);
    pwm_d      = (cnt_q < cur_pw);
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/servo_cmd_sched.sv
// Two-requester pulse-width scheduler: B overrides and locks out A, targets are clamped,
// and the applied pulse width slews toward the target by at most STEP per frame.
module servo_cmd_sched
  import servo_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned MIN_PW       = DEF_MIN_PW,
  parameter int unsigned MAX_PW       = DEF_MAX_PW,
  parameter int unsigned INIT_PW      = DEF_INIT_PW,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic             req_a_valid,
  input  logic [WIDTH-1:0] req_a_pw,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [WIDTH-1:0] req_b_pw,
  output logic             req_b_ready,
  output logic             pwm_out,
  output logic [WIDTH-1:0] cur_pw,
  output logic             busy,
  output logic             at_target,
  output logic             frame_tick,
  output logic             clamp_err
);

  localparam int unsigned      XW     = WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_PW);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_PW);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_PW);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] HOLD_V = WIDTH'(HOLD_FRAMES);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] lock_q, lock_d;
  logic             clamp_q, clamp_d;

  logic             acc_a, acc_b, accept;
  logic [WIDTH-1:0] raw_pw, clamped_pw, ramp_pw;
  logic [XW-1:0]    up_x, dn_lim_x;

  servo_pwm_frame #(
    .WIDTH        (WIDTH),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_frame (
    .clock_clk  (clock_clk),
    .reset_low  (reset_low),
    .cur_pw     (cur_q),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  // Handshake and target clamp; B always wins a simultaneous request.
  always_comb begin
    req_b_ready = reset_low;
    req_a_ready = reset_low && (lock_q == '0) && !req_b_valid;
    acc_b       = req_b_valid && req_b_ready;
    acc_a       = req_a_valid && req_a_ready;
    accept      = acc_a || acc_b;
    raw_pw      = acc_b ? req_b_pw : req_a_pw;
    if (raw_pw < MIN_V) begin
      clamped_pw = MIN_V;
    end else if (raw_pw > MAX_V) begin
      clamped_pw = MAX_V;
    end else begin
      clamped_pw = raw_pw;
    end
  end

  // Slew toward the target held before this cycle; sums carry one extra bit so nothing wraps.
  always_comb begin
    up_x     = {1'b0, cur_q} + XW'(STEP);
    dn_lim_x = {1'b0, tgt_q} + XW'(STEP);
    ramp_pw  = cur_q;
    if (cur_q < tgt_q) begin
      ramp_pw = (up_x >= {1'b0, tgt_q}) ? tgt_q : cur_q + STEP_V;
    end else if (cur_q > tgt_q) begin
      ramp_pw = ({1'b0, cur_q} <= dn_lim_x) ? tgt_q : cur_q - STEP_V;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = frame_tick ? ramp_pw : cur_q;
    tgt_d   = accept ? clamped_pw : tgt_q;
    clamp_d = accept && (clamped_pw != raw_pw);
    lock_d  = lock_q;
    if (acc_b) begin
      lock_d = HOLD_V;
    end else if (frame_tick && (lock_q != '0)) begin
      lock_d = lock_q - WIDTH'(1);
    end
    case (state_q)
      ST_IDLE: if (accept && (tgt_d != cur_d)) state_d = ST_RAMP;
      ST_RAMP: if (cur_d == tgt_d)             state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q <= ST_IDLE;
      cur_q   <= INIT_V;
      tgt_q   <= INIT_V;
      lock_q  <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      lock_q  <= lock_d;
      clamp_q <= clamp_d;
    end
  end

  assign cur_pw    = cur_q;
  assign busy      = (state_q == ST_RAMP);
  assign at_target = (state_q == ST_IDLE);
  assign clamp_err = clamp_q;

endmodule

// File: tb/tb_servo_cmd_sched.sv
// Randomized and directed bench for servo_cmd_sched against a frame-level behavioural model.
module tb_servo_cmd_sched;

  localparam int F    = 100;
  localparam int MINP = 10;
  localparam int MAXP = 20;
  localparam int INIT = 15;
  localparam int STP  = 3;
  localparam int HOLD = 2;

  logic        clock_clk = 1'b0;
  logic        reset_low = 1'b0;
  logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic [31:0] req_a_pw = '0, req_b_pw = '0;
  logic        req_a_ready, req_b_ready, pwm_out, busy, at_target, frame_tick, clamp_err;
  logic [31:0] cur_pw;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: position in frame, applied width, target, lockout frames, last pwm/clamp outputs.
  int m_cnt, m_cur, m_tgt, m_lock, m_pwm, m_clamp;

  servo_cmd_sched #(
    .WIDTH(32), .FRAME_CYCLES(F), .MIN_PW(MINP), .MAX_PW(MAXP),
    .INIT_PW(INIT), .STEP(STP), .HOLD_FRAMES(HOLD)
  ) dut (
    .clock_clk   (clock_clk),
    .reset_low   (reset_low),
    .req_a_valid (req_a_valid),
    .req_a_pw    (req_a_pw),
    .req_a_ready (req_a_ready),
    .req_b_valid (req_b_valid),
    .req_b_pw    (req_b_pw),
    .req_b_ready (req_b_ready),
    .pwm_out     (pwm_out),
    .cur_pw      (cur_pw),
    .busy        (busy),
    .at_target   (at_target),
    .frame_tick  (frame_tick),
    .clamp_err   (clamp_err)
  );

  always #5 clock_clk = ~clock_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cur = INIT; m_tgt = INIT; m_lock = 0; m_pwm = 0; m_clamp = 0;
  endtask

  // One clock of the behavioural rules, using inputs present before the edge.
  task automatic model_update(input logic av, input logic [31:0] apw,
                              input logic bv, input logic [31:0] bpw);
    bit     tick, acc;
    longint raw;
    int     clamped;
    tick = (m_cnt == F - 1);
    acc  = 1'b0;
    raw  = 0;
    if (bv) begin
      acc = 1'b1; raw = longint'(bpw);
    end else if (av && m_lock == 0) begin
      acc = 1'b1; raw = longint'(apw);
    end
    m_pwm = (m_cnt < m_cur) ? 1 : 0;
    if (tick) begin
      if (m_cur < m_tgt)      m_cur = (m_cur + STP < m_tgt) ? m_cur + STP : m_tgt;
      else if (m_cur > m_tgt) m_cur = (m_cur - STP > m_tgt) ? m_cur - STP : m_tgt;
    end
    if (bv)                       m_lock = HOLD;
    else if (tick && m_lock > 0)  m_lock = m_lock - 1;
    clamped = (raw < MINP) ? MINP : (raw > MAXP) ? MAXP : int'(raw);
    m_clamp = (acc && (raw < MINP || raw > MAXP)) ? 1 : 0;
    if (acc) m_tgt = clamped;
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    chk("pwm_out",   32'(pwm_out),     32'(m_pwm));
    chk("cur_pw",    cur_pw,           32'(m_cur));
    chk("busy",      32'(busy),        32'(m_cur != m_tgt));
    chk("at_target", 32'(at_target),   32'(m_cur == m_tgt));
    chk("frame_tick",32'(frame_tick),  32'(m_cnt == F - 1));
    chk("clamp_err", 32'(clamp_err),   32'(m_clamp));
    chk("rdy_a",     32'(req_a_ready), 32'(m_lock == 0 && !req_b_valid));
    chk("rdy_b",     32'(req_b_ready), 32'd1);
  endtask

  // Starts and ends on a falling edge; one full clock with the given inputs.
  task automatic step(input logic av, input logic [31:0] apw,
                      input logic bv, input logic [31:0] bpw);
    req_a_valid = av; req_a_pw = apw; req_b_valid = bv; req_b_pw = bpw;
    #1;
    check_all();
    @(posedge clock_clk);
    model_update(av, apw, bv, bpw);
    @(negedge clock_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic go_to(input int c);
    int guard;
    guard = 0;
    while (m_cnt != c && guard < 2 * F) begin
      step(1'b0, 32'd0, 1'b0, 32'd0);
      guard++;
    end
    if (m_cnt != c) chk("go_to_bound", 32'(m_cnt), 32'(c));
  endtask

  // Asynchronous reset asserted just after a falling edge, released three cycles later.
  task automatic do_reset();
    req_a_valid = 1'b1; req_b_valid = 1'b0;
    reset_low = 1'b0;
    model_reset();
    #1;
    chk("rst_pwm",   32'(pwm_out),     32'd0);
    chk("rst_cur",   cur_pw,           32'(INIT));
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_at",    32'(at_target),   32'd1);
    chk("rst_tick",  32'(frame_tick),  32'd0);
    chk("rst_clamp", 32'(clamp_err),   32'd0);
    chk("rst_rdy_a", 32'(req_a_ready), 32'd0);
    chk("rst_rdy_b", 32'(req_b_ready), 32'd0);
    repeat (3) @(negedge clock_clk);
    req_a_valid = 1'b0;
    reset_low = 1'b1;
  endtask

  initial begin
    int guard;
    @(negedge clock_clk);
    do_reset();

    // Idle frames: centre width, periodic tick.
    idle(250);

    // A ramps up from centre to the top in two frames.
    go_to(50);
    step(1'b1, 32'd20, 1'b0, 32'd0);
    chk("s2_busy", 32'(busy), 32'd1);
    go_to(1);
    chk("s2_cur1", cur_pw, 32'd18);
    idle(100);
    chk("s2_cur2", cur_pw, 32'd20);
    chk("s2_at", 32'(at_target), 32'd1);

    // Out-of-range requests clamp and pulse clamp_err for one cycle.
    step(1'b1, 32'd40, 1'b0, 32'd0);
    chk("s3_clamp_hi", 32'(clamp_err), 32'd1);
    idle(1);
    chk("s3_clamp_off", 32'(clamp_err), 32'd0);
    step(1'b1, 32'd3, 1'b0, 32'd0);
    chk("s3_clamp_lo", 32'(clamp_err), 32'd1);
    idle(500);
    chk("s3_cur", cur_pw, 32'd10);

    // Simultaneous requests: B wins and locks A out for two frames.
    go_to(50);
    step(1'b1, 32'd12, 1'b1, 32'd18);
    chk("s4_busy", 32'(busy), 32'd1);
    go_to(1);
    chk("s4_lock1", 32'(req_a_ready), 32'd0);
    idle(100);
    chk("s4_lock0", 32'(req_a_ready), 32'd1);
    idle(300);
    chk("s4_cur", cur_pw, 32'd18);

    // Accept on the tick cycle only takes effect at the following tick.
    do_reset();
    go_to(F - 1);
    step(1'b1, 32'd18, 1'b0, 32'd0);
    chk("s5_cur_hold", cur_pw, 32'd15);
    idle(100);
    chk("s5_cur_next", cur_pw, 32'd18);

    // Reset in the middle of a ramp while the output is high.
    step(1'b1, 32'd10, 1'b0, 32'd0);
    go_to(F - 1);
    guard = 0;
    while (!(pwm_out === 1'b1 && m_pwm == 1) && guard < 2 * F) begin
      step(1'b0, 32'd0, 1'b0, 32'd0);
      guard++;
    end
    chk("s6_pwm_high", 32'(pwm_out), 32'd1);
    chk("s6_busy", 32'(busy), 32'd1);
    do_reset();
    idle(2);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic        av, bv;
      logic [31:0] apw, bpw;
      av  = ($urandom_range(0, 7) == 0);
      bv  = ($urandom_range(0, 59) == 0);
      apw = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 30));
      bpw = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 30));
      if ($urandom_range(0, 1499) == 0) do_reset();
      else step(av, apw, bv, bpw);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
